// File: rtl/tlc_mk2_pkg.sv
// Shared types and constants for the Mk2 traffic light controller.
// Phase lives in y[3:2]; y[1:0] is a sub-step that never reaches the lamps.
package tlc_mk2_pkg;

    typedef enum logic [1:0] {
        PH_NS_G = 2'b00,
        PH_NS_Y = 2'b01,
        PH_EW_G = 2'b10,
        PH_EW_Y = 2'b11
    } phase_e;

    typedef enum logic [1:0] {
        W_HOLD  = 2'b00,
        W_RUN_A = 2'b01,
        W_RUN_B = 2'b10,
        W_FLASH = 2'b11
    } mode_e;

    // Lamp encoding is {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic logic phase_is_green(input logic [1:0] ph_bits);
        phase_e ph;
        ph = phase_e'(ph_bits);
        return (ph == PH_NS_G) || (ph == PH_EW_G);
    endfunction

    // Returns {ns_light, ew_light} for a phase
    function automatic logic [5:0] lamp_decode(input logic [1:0] ph_bits);
        phase_e ph;
        ph = phase_e'(ph_bits);
        case (ph)
            PH_NS_G: return {LAMP_GRN, LAMP_RED};
            PH_NS_Y: return {LAMP_YEL, LAMP_RED};
            PH_EW_G: return {LAMP_RED, LAMP_GRN};
            default: return {LAMP_RED, LAMP_YEL};
        endcase
    endfunction

endpackage

// File: rtl/tlc_mk2_state_sequencer_tick_gen.sv
// Prescaler: counts 0..CLK_DIV-1 while enabled, pulses tick on the last count.
// Holding en low freezes the count so a later resume continues mid-period.
module tlc_mk2_tick_gen #(
    parameter int unsigned CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next count and tick; tick is gated so a frozen count never re-fires
    always_comb begin
        tick  = en && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Prescaler register
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tlc_mk2_state_sequencer.sv
// Mk2 state register, dwell timer and lamp decoder.
// Optional feature: define TLC_MK2_FLASH_EN to make w=11 flash both roads yellow.
module tlc_mk2_state_sequencer #(
    parameter int unsigned CLK_DIV      = 50_000_000,
    parameter int unsigned GREEN_TICKS  = 8,
    parameter int unsigned YELLOW_TICKS = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] w,
    input  logic [3:0] X,
    output logic [3:0] y,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       step
);
    import tlc_mk2_pkg::*;

    localparam int unsigned DMAX = ((GREEN_TICKS > YELLOW_TICKS) ? GREEN_TICKS : YELLOW_TICKS) - 1;
    localparam int unsigned DW   = (DMAX > 0) ? $clog2(DMAX + 1) : 1;
    localparam logic [DW-1:0] DWELL_GRN = DW'(GREEN_TICKS - 1);
    localparam logic [DW-1:0] DWELL_YEL = DW'(YELLOW_TICKS - 1);

    mode_e         mode;
    logic          run;
    logic          presc_en;
    logic          tick;
    logic [3:0]    y_q, y_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic          step_q, step_d;
`ifdef TLC_MK2_FLASH_EN
    logic          flash;
    logic          tog_q, tog_d;
`endif

    // Mode decode and prescaler enable (flash keeps the prescaler running)
    always_comb begin
        mode = mode_e'(w);
        run  = (mode == W_RUN_A) || (mode == W_RUN_B);
`ifdef TLC_MK2_FLASH_EN
        flash    = (mode == W_FLASH);
        presc_en = run || flash;
`else
        presc_en = run;
`endif
    end

    tlc_mk2_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (presc_en),
        .tick(tick)
    );

    // Dwell countdown and state load; X is only looked at on the expiring tick
    always_comb begin
        y_d     = y_q;
        dwell_d = dwell_q;
        step_d  = 1'b0;
        if (tick && run) begin
            if (dwell_q == '0) begin
                y_d     = X;
                dwell_d = phase_is_green(X[3:2]) ? DWELL_GRN : DWELL_YEL;
                step_d  = 1'b1;
            end else begin
                dwell_d = dwell_q - 1'b1;
            end
        end
`ifdef TLC_MK2_FLASH_EN
        tog_d = 1'b0;
        if (flash) begin
            tog_d = tick ? ~tog_q : tog_q;
        end
`endif
    end

    // State, dwell and step registers
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            dwell_q <= DWELL_GRN;
            step_q  <= 1'b0;
`ifdef TLC_MK2_FLASH_EN
            tog_q   <= 1'b0;
`endif
        end else begin
            y_q     <= y_d;
            dwell_q <= dwell_d;
            step_q  <= step_d;
`ifdef TLC_MK2_FLASH_EN
            tog_q   <= tog_d;
`endif
        end
    end

    // Lamp decode; flash overrides combinationally so leaving w=11 is immediate
    always_comb begin
        {ns_light, ew_light} = lamp_decode(y_q[3:2]);
`ifdef TLC_MK2_FLASH_EN
        if (flash) begin
            ns_light = tog_q ? LAMP_YEL : LAMP_OFF;
            ew_light = tog_q ? LAMP_YEL : LAMP_OFF;
        end
`endif
    end

    assign y    = y_q;
    assign step = step_q;

endmodule
